// File: rtl/run_ctrl_pkg.sv
// Shared types for the program-run controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        TOUT = 2'd3
    } run_state_t;

    // Encoding of the branch_type input.
    localparam logic BR_UNCOND = 1'b0;
    localparam logic BR_COND   = 1'b1;

endpackage

// File: rtl/run_ctrl_next_pc.sv
// Combinational next-PC select for a RUN cycle: hold, branch target or pc+1.
// Latency: purely combinational, zero cycles.
// Backpressure: stall, halt or a watchdog hit hold the PC.
module next_pc
    import run_ctrl_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic [PW-1:0] pc_i,
    input  logic          stall_i,
    input  logic          halt_i,
    input  logic          wd_hit_i,
    input  logic          branch_en_i,
    input  logic          branch_type_i,
    input  logic          cmp0_i,
    input  logic [PW-1:0] branch_target_i,
    output logic [PW-1:0] pc_next_o
);

    logic taken;

    assign taken = branch_en_i & ((branch_type_i == BR_UNCOND) | cmp0_i);

    // Stall, halt and the watchdog all freeze the PC; otherwise branch or step.
    // pc+1 wraps naturally at the PW-bit boundary.
    always_comb begin
        pc_next_o = pc_i + 1'b1;
        if (stall_i || halt_i || wd_hit_i) begin
            pc_next_o = pc_i;
        end else if (taken) begin
            pc_next_o = branch_target_i;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Program-run controller: owns the PC, entry-point select, run/done handshake, cycle counter, watchdog.
// Latency: start seen at edge k gives run=1 and pc=base from k+1; halt/timeout flags one edge after the deciding cycle.
// Backpressure: stall holds the PC for a cycle but still counts toward the watchdog.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          PW    = 8,
    parameter int          NPROG = 4,
    parameter int          CW    = 16,
    parameter int unsigned WDOG  = (2 ** CW) - 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [((NPROG > 1) ? $clog2(NPROG) : 1)-1:0] prog_sel,
    input  logic [NPROG*PW-1:0]                     prog_base,
    input  logic                                    branch_en,
    input  logic                                    branch_type,
    input  logic [7:0]                              cmp,
    input  logic [PW-1:0]                           branch_target,
    input  logic                                    halt,
    input  logic                                    stall,
    output logic [PW-1:0]                           pc,
    output logic                                    run,
    output logic                                    done,
    output logic                                    timeout,
    output logic [CW-1:0]                           cycles
);

    run_state_t    state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          run_q, done_q, tout_q;
    logic [PW-1:0] base_sel;
    logic [PW-1:0] pc_step;
    logic          wd_hit;
    logic          unused_cmp_hi;

    // Only the low compare bit steers conditional branches.
    assign unused_cmp_hi = ^cmp[7:1];

    // Watchdog fires in the RUN cycle that would bring the count up to WDOG.
    assign wd_hit = (cycles_q == CW'(WDOG - 1));

    // Entry-point mux; an index beyond NPROG-1 falls back to entry 0.
    always_comb begin
        base_sel = prog_base[PW-1:0];
        for (int unsigned i = 0; i < NPROG; i++) begin
            if (32'(prog_sel) == i) begin
                base_sel = prog_base[i*PW +: PW];
            end
        end
    end

    next_pc #(.PW(PW)) u_next_pc (
        .pc_i            (pc_q),
        .stall_i         (stall),
        .halt_i          (halt),
        .wd_hit_i        (wd_hit),
        .branch_en_i     (branch_en),
        .branch_type_i   (branch_type),
        .cmp0_i          (cmp[0]),
        .branch_target_i (branch_target),
        .pc_next_o       (pc_step)
    );

    // Next-state logic: start handling outside RUN; stall < watchdog, halt > watchdog inside RUN.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cycles_d = cycles_q;
        case (state_q)
            IDLE, DONE, TOUT: begin
                if (start) begin
                    state_d  = RUN;
                    pc_d     = base_sel;
                    cycles_d = '0;
                end
            end
            RUN: begin
                cycles_d = cycles_q + 1'b1;
                pc_d     = pc_step;
                if (stall) begin
                    if (wd_hit) begin
                        state_d = TOUT;
                    end
                end else if (halt) begin
                    state_d = DONE;
                end else if (wd_hit) begin
                    state_d = TOUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC, counter and registered status flags; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            cycles_q <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cycles_q <= cycles_d;
            run_q    <= (state_d == RUN);
            done_q   <= (state_d == DONE) || (state_d == TOUT);
            tout_q   <= (state_d == TOUT);
        end
    end

    assign pc      = pc_q;
    assign run     = run_q;
    assign done    = done_q;
    assign timeout = tout_q;
    assign cycles  = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl with PW=8, NPROG=3, CW=16, WDOG=20.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked at the same point.
// Backpressure: stall exercised together with halt and with the watchdog.
module tb_run_ctrl;

    localparam int PW    = 8;
    localparam int NPROG = 3;
    localparam int CW    = 16;
    localparam int WDOG  = 20;

    logic                clk;
    logic                reset;
    logic                start;
    logic [1:0]          prog_sel;
    logic [NPROG*PW-1:0] prog_base;
    logic                branch_en;
    logic                branch_type;
    logic [7:0]          cmp;
    logic [PW-1:0]       branch_target;
    logic                halt;
    logic                stall;
    logic [PW-1:0]       pc;
    logic                run;
    logic                done;
    logic                timeout;
    logic [CW-1:0]       cycles;

    int n_checks;
    int n_errors;

    run_ctrl #(.PW(PW), .NPROG(NPROG), .CW(CW), .WDOG(WDOG)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .prog_sel      (prog_sel),
        .prog_base     (prog_base),
        .branch_en     (branch_en),
        .branch_type   (branch_type),
        .cmp           (cmp),
        .branch_target (branch_target),
        .halt          (halt),
        .stall         (stall),
        .pc            (pc),
        .run           (run),
        .done          (done),
        .timeout       (timeout),
        .cycles        (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] sel);
        start    = 1'b1;
        prog_sel = sel;
        step();
        start    = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        start         = 1'b0;
        prog_sel      = 2'd0;
        prog_base     = {8'h40, 8'h50, 8'hFE};
        branch_en     = 1'b0;
        branch_type   = 1'b0;
        cmp           = 8'h00;
        branch_target = 8'h00;
        halt          = 1'b0;
        stall         = 1'b0;

        #1;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_run", 32'(run), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_tout", 32'(timeout), 32'h0);
        chk("rst_cycles", 32'(cycles), 32'h0);

        step();
        reset = 1'b1;
        step();
        chk("idle_run", 32'(run), 32'h0);

        // Entry 2, sequential stepping.
        do_start(2'd2);
        chk("start_run", 32'(run), 32'h1);
        chk("start_pc", 32'(pc), 32'h40);
        chk("start_done", 32'(done), 32'h0);
        chk("start_cycles", 32'(cycles), 32'h0);
        step();
        chk("seq_pc41", 32'(pc), 32'h41);
        step();
        chk("seq_pc42", 32'(pc), 32'h42);
        chk("seq_cycles", 32'(cycles), 32'h2);

        // Branch variants.
        branch_en = 1'b1; branch_type = 1'b0; branch_target = 8'h10;
        step();
        chk("br_uncond", 32'(pc), 32'h10);
        branch_type = 1'b1; cmp = 8'h00; branch_target = 8'h77;
        step();
        chk("br_cond_nt", 32'(pc), 32'h11);
        cmp = 8'h01; branch_target = 8'h30;
        step();
        chk("br_cond_t", 32'(pc), 32'h30);
        chk("br_cycles", 32'(cycles), 32'h5);
        branch_en = 1'b0; cmp = 8'h00;

        // Stall masks halt.
        stall = 1'b1; halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", 32'(pc), 32'h30);
            chk("stall_done", 32'(done), 32'h0);
            chk("stall_cycles", 32'(cycles), 32'(6 + i));
        end
        stall = 1'b0;
        step();
        chk("halt_done", 32'(done), 32'h1);
        chk("halt_run", 32'(run), 32'h0);
        chk("halt_pc", 32'(pc), 32'h30);
        chk("halt_cycles", 32'(cycles), 32'h9);
        chk("halt_tout", 32'(timeout), 32'h0);
        halt = 1'b0;

        // Halt in the 6th RUN cycle.
        do_start(2'd1);
        chk("h6_pc", 32'(pc), 32'h50);
        repeat (5) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("h6_cycles", 32'(cycles), 32'h6);
        chk("h6_done", 32'(done), 32'h1);
        chk("h6_run", 32'(run), 32'h0);
        chk("h6_pc_hold", 32'(pc), 32'h55);

        // Restart from DONE, then let the watchdog expire.
        do_start(2'd1);
        chk("rs_cycles", 32'(cycles), 32'h0);
        chk("rs_done", 32'(done), 32'h0);
        chk("rs_run", 32'(run), 32'h1);
        repeat (19) step();
        chk("wd_pre_run", 32'(run), 32'h1);
        step();
        chk("wd_tout", 32'(timeout), 32'h1);
        chk("wd_done", 32'(done), 32'h1);
        chk("wd_run", 32'(run), 32'h0);
        chk("wd_cycles", 32'(cycles), 32'd20);
        chk("wd_pc", 32'(pc), 32'h63);

        // Halt coinciding with the watchdog limit: halt wins.
        do_start(2'd1);
        chk("hw_tout_clr", 32'(timeout), 32'h0);
        repeat (19) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("hw_tout", 32'(timeout), 32'h0);
        chk("hw_done", 32'(done), 32'h1);
        chk("hw_cycles", 32'(cycles), 32'd20);

        // Watchdog still fires while stalled.
        do_start(2'd1);
        stall = 1'b1;
        repeat (20) step();
        stall = 1'b0;
        chk("sw_tout", 32'(timeout), 32'h1);
        chk("sw_pc", 32'(pc), 32'h50);
        chk("sw_cycles", 32'(cycles), 32'd20);

        // Out-of-range select falls back to entry 0 (0xFE); PC wraps.
        do_start(2'd3);
        chk("wrap_fe", 32'(pc), 32'hFE);
        step();
        chk("wrap_ff", 32'(pc), 32'hFF);
        step();
        chk("wrap_00", 32'(pc), 32'h00);
        chk("wrap_run", 32'(run), 32'h1);

        // Asynchronous reset mid-cycle.
        #3;
        reset = 1'b0;
        #1;
        chk("arst_pc", 32'(pc), 32'h0);
        chk("arst_run", 32'(run), 32'h0);
        chk("arst_cycles", 32'(cycles), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        #1;
        reset = 1'b1;
        step();
        chk("post_rst_run", 32'(run), 32'h0);
        chk("post_rst_pc", 32'(pc), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Parametrised program-run controller replacing the fixed 8-bit PC and `done = Halt & ~reset` logic of the single-cycle core's top level. It owns the program counter, selects one of several program entry points, applies sequential/branch/halt next-PC rules, and gives the test harness a start/done handshake. It also provides a cycle counter and a watchdog timeout. It sits between the decoder/ALU (branch, halt, cmp inputs) and the instruction ROM (pc output).

## Interface
- `PW`, 8: PC width; instruction ROM depth is 2**PW.
- `NPROG`, 4: number of selectable program entry points (≥1).
- `CW`, 16: cycle-counter width.
- `WDOG`, 2**CW-1: watchdog limit in RUN cycles; must satisfy 1 ≤ WDOG ≤ 2**CW-1.

- `clk` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `start` input 1: run request; sampled in IDLE, DONE, TOUT; ignored in RUN.
- `prog_sel` input $clog2(NPROG) (min 1): entry-point index, sampled with `start`.
- `prog_base` input NPROG*PW: packed entry addresses, entry i at [i*PW +: PW].
- `branch_en` input 1: current instruction is a branch.
- `branch_type` input 1: 0 = unconditional, 1 = conditional on `cmp[0]`.
- `cmp` input 8: compare register; only bit 0 is used.
- `branch_target` input PW: absolute target from the branch LUT.
- `halt` input 1: current instruction is halt.
- `stall` input 1: holds PC for this cycle (multi-cycle memory).
- `pc` output PW: instruction address.
- `run` output 1: core executing; gates reg-file and memory writes.
- `done` output 1: run finished (halt or timeout); sticky until the next accepted start.
- `timeout` output 1: run ended by the watchdog.
- `cycles` output CW: RUN cycles elapsed in the current or last run.

## Operation
- States: IDLE, RUN, DONE, TOUT.
- Reset values: state = IDLE, `pc` = 0, `run` = 0, `done` = 0, `timeout` = 0, `cycles` = 0.
- IDLE/DONE/TOUT with `start` = 1:
  - pc ← prog_base[prog_sel], cycles ← 0, done ← 0, timeout ← 0, state → RUN.
  - An out-of-range `prog_sel` selects entry 0.
- RUN, each edge, evaluated in priority order:
  1. `stall` = 1: pc holds, halt and branch are ignored, cycles increments.
  2. `halt` = 1: state → DONE, pc holds, cycles increments.
  3. `cycles` == WDOG-1: state → TOUT, pc holds, cycles increments to WDOG.
  4. Branch taken (`branch_en` & (~`branch_type` | `cmp[0]`)): pc ← branch_target, cycles increments.
  5. Otherwise: pc ← pc+1, cycles increments.
- Precedence between the watchdog and stall: when `cycles` == WDOG-1, the watchdog fires even if `stall` = 1.
- Halt takes precedence over the watchdog and over branch in the same cycle.
- pc+1 wraps modulo 2**PW (all-ones → 0); no flag is raised.
- `cycles` never exceeds WDOG, so no saturation logic is needed.
- `run` = (state == RUN); `done` = state ∈ {DONE, TOUT}; `timeout` = (state == TOUT). All are registered.
- `start` held high in RUN has no effect. If it is still high on entry to DONE, a new run starts on the next edge.

## Timing
- Start accepted at edge k: from k+1, `run` = 1 and `pc` = selected base.
- First instruction executes in cycle k+1.
- Halt decoded in a cycle with pc = P: at the next edge `run` = 0, `done` = 1, and `pc` stays P.
- `cycles` equals the number of RUN cycles, including the halt cycle.
- Branch: target visible on `pc` one edge after the branch cycle. No delay slot.
- Asserting `reset` low at any time, including mid-run, forces all outputs to their reset values without waiting for a clock edge.
- Deasserting `reset` leaves the block in IDLE; it needs `start` to run.

## Structure
- Package `run_ctrl_pkg` holds:
  - `run_state_t` enum {IDLE, RUN, DONE, TOUT};
  - `BR_UNCOND` = 1'b0, `BR_COND` = 1'b1.
- Sub-module `next_pc`: combinational next-PC select implementing priorities 1–5, parametrised by PW.
- The state register, `cycles` counter and watchdog compare stay in `run_ctrl`.

## Test plan
- Reset, then `start` with prog_sel = 2, base2 = 0x40 → `run` = 1, pc = 0x40, then 0x41, 0x42 on following edges; `done` = 0.
- At pc = 0x42:
  - unconditional branch, target 0x10 → pc = 0x10;
  - conditional branch with cmp = 0x00 → pc = 0x11;
  - conditional branch with cmp = 0x01, target 0x30 → pc = 0x30.
- `stall` held 3 cycles at pc = 0x30 with `halt` = 1 throughout → pc stays 0x30, cycles +3, no done. Drop stall → done = 1 next edge, pc = 0x30.
- Halt in the 6th RUN cycle → cycles = 6, done = 1, run = 0. Then `start` → cycles = 0, done = 0, run = 1 next edge.
- WDOG = 20, no halt → after 20 RUN cycles timeout = 1, done = 1, cycles = 20. Halt and the watchdog limit in the same cycle → timeout = 0, done = 1.
- base = 0xFE, PW = 8: pc runs 0xFE, 0xFF, 0x00. `reset` pulsed low mid-cycle → pc, run, cycles = 0 before the next edge.
